sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 4: number of bits per parallel word (legal 2..32).
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first received bit lands in parallel_out[WIDTH-1]; 0 means it lands in parallel_out[0].
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port shift_en, input, 1: serial_in is sampled on this edge.
REQ-006 Port serial_in, input, 1: serial data bit.
REQ-007 Port frame_clr, input, 1: discards any partial word and restarts bit counting.
REQ-008 Port parallel_out, output, WIDTH: holding register, the last completed word.
REQ-009 Port out_valid, output, 1: parallel_out holds an unconsumed word.
REQ-010 Port out_ready, input, 1: consumer accepts the word when out_valid && out_ready.
REQ-011 Port bit_cnt, output, $clog2(WIDTH): bits collected in the current partial word.
REQ-012 Port overrun, output, 1: sticky flag, a completed word was dropped.
REQ-013 Port ovr_clr, input, 1: clears overrun.

Function
REQ-014 Shift register samples serial_in on each edge with shift_en=1; bit_cnt increments by 1.
REQ-015 With shift_en=0, shift register and bit_cnt hold.
REQ-016 Completion: the edge with shift_en=1 and bit_cnt==WIDTH-1 completes a word; bit_cnt wraps to 0 on that edge.
REQ-017 Completed word = the WIDTH sampled bits, ordered per MSB_FIRST; the holding register loads on the completing edge.
REQ-018 Latency: out_valid=1 and parallel_out is valid starting the cycle after the completing edge, with no additional delay.
REQ-019 Holding FSM has two states:
- EMPTY (out_valid=0).
- FULL (out_valid=1).
REQ-020 EMPTY -> FULL on completion.
REQ-021 FULL -> EMPTY on accept (out_valid && out_ready) without completion.
REQ-022 FULL plus simultaneous accept and completion: load the new word, stay FULL, no overrun.
REQ-023 FULL plus completion without accept: keep the old word, discard the new word, set overrun.
REQ-024 parallel_out and out_valid shall stay stable while FULL and not accepted.
REQ-025 out_ready while EMPTY has no effect.
REQ-026 frame_clr: on the next edge, bit_cnt=0 and the partial word is discarded; the holding register and FSM are unaffected.
REQ-027 frame_clr has priority over shift_en on the same edge; that bit is not sampled and no completion occurs.
REQ-028 Overrun:
- ovr_clr clears overrun on the next edge.
- A simultaneous set (REQ-023) wins: overrun stays 1.
REQ-029 Shift and handshake proceed in parallel: receiving continues while FULL.

Reset
REQ-030 Synchronous reset values:
- rst=1 at an edge forces parallel_out=0, out_valid=0 (EMPTY), bit_cnt=0, overrun=0, shift register=0.
REQ-031 rst has priority over every other input, including mid-word and while FULL; the partial word and any held word are lost.
REQ-032 The first edge after rst deasserts with shift_en=1 samples bit 0 of a new word.

Structure
REQ-033 Shared package sipo_pkg holds:
- the FSM state typedef (EMPTY, FULL);
- constant DEFAULT_WIDTH=4.
REQ-034 One sub-module, sipo_shreg, contains the shift register and bit counter and produces a one-cycle "done" strobe plus the completed word; sipo_deser contains the FSM, holding register and overrun logic.
REQ-035 All outputs are driven directly from flops, with no combinational paths from inputs to outputs.

Verification
REQ-036 Basic receive: WIDTH=4, MSB_FIRST=1, shift_en=1 for 4 cycles with serial_in 1,1,0,1 and out_ready=0 -> next cycle out_valid=1, parallel_out=4'hD, bit_cnt=0.
REQ-037 Bit order: same bits with MSB_FIRST=0 -> parallel_out=4'hB.
REQ-038 Overrun: FULL with 4'hD, out_ready=0, then stream 0,1,1,0 -> parallel_out stays 4'hD, overrun=1; then ovr_clr=1 for one cycle -> overrun=0.
REQ-039 Simultaneous events: FULL with 4'hD, out_ready=1 on the edge completing 1,0,1,0 -> out_valid stays 1, parallel_out=4'hA, overrun=0.
REQ-040 frame_clr mid-word: shift 1,1, then frame_clr=1 with shift_en=1, then shift 0,0,1,1 -> bit_cnt=0 after clear, word=4'h3, no completion from the discarded bits.
REQ-041 Reset mid-operation: rst=1 with FULL and bit_cnt=2 -> next cycle out_valid=0, parallel_out=0, bit_cnt=0, overrun=0; the following 4 bits 1,1,0,1 give 4'hD.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out deserializer.
package sipo_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } hold_state_t;

   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sipo_shreg.sv
// Shift register and bit counter; flags the edge that completes a word and
// presents that word combinationally so the holder can load on the same edge.
module sipo_shreg
   import sipo_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CW        = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             serial_in,
   input  logic             frame_clr,
   output logic [CW-1:0]    bit_cnt,
   output logic             done,
   output logic [WIDTH-1:0] word
);

   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_next;
   logic [CW-1:0]    cnt_reg;

   // MSB-first enters at bit 0 and moves up; LSB-first enters at the top and moves down.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_in
               assign shift_next[gi] = serial_in;
            end else begin : g_mv
               assign shift_next[gi] = shift_reg[gi-1];
            end
         end else begin : g_lsb
            if (gi == WIDTH-1) begin : g_in
               assign shift_next[gi] = serial_in;
            end else begin : g_mv
               assign shift_next[gi] = shift_reg[gi+1];
            end
         end
      end
   endgenerate

   assign done    = shift_en && !frame_clr && (cnt_reg == CW'(WIDTH-1));
   assign word    = shift_next;
   assign bit_cnt = cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || frame_clr) begin
         shift_reg <= '0;
         cnt_reg   <= '0;
      end else if (shift_en) begin
         shift_reg <= shift_next;
         cnt_reg   <= done ? '0 : cnt_reg + CW'(1);
      end
   end

endmodule

// File: rtl/sipo_deser.sv
// Deserializer top: one-word holding register with valid/ready handshake and
// a sticky overrun flag for words completed while the holder is still full.
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     shift_en,
   input  logic                     serial_in,
   input  logic                     frame_clr,
   output logic [WIDTH-1:0]         parallel_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(WIDTH)-1:0] bit_cnt,
   output logic                     overrun,
   input  logic                     ovr_clr
);

   localparam int CW = $clog2(WIDTH);

   logic             done;
   logic [WIDTH-1:0] word;

   hold_state_t      state_reg, state_next;
   logic [WIDTH-1:0] hold_reg, hold_next;
   logic             overrun_reg, overrun_next;
   logic             valid_reg;
   logic             accept;

   sipo_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST),
      .CW        (CW)
   ) u_shreg (
      .clk       (clk),
      .rst       (rst),
      .shift_en  (shift_en),
      .serial_in (serial_in),
      .frame_clr (frame_clr),
      .bit_cnt   (bit_cnt),
      .done      (done),
      .word      (word)
   );

   assign accept = (state_reg == FULL) && out_ready;

   always_comb begin
      state_next   = state_reg;
      hold_next    = hold_reg;
      overrun_next = overrun_reg;
      if (ovr_clr) begin
         overrun_next = 1'b0;
      end
      unique case (state_reg)
         EMPTY: begin
            if (done) begin
               state_next = FULL;
               hold_next  = word;
            end
         end
         FULL: begin
            if (done && accept) begin
               hold_next = word;
            end else if (done) begin
               // Old word is kept; dropping the new one beats a pending clear.
               overrun_next = 1'b1;
            end else if (accept) begin
               state_next = EMPTY;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= EMPTY;
         hold_reg    <= '0;
         overrun_reg <= 1'b0;
         valid_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         hold_reg    <= hold_next;
         overrun_reg <= overrun_next;
         valid_reg   <= (state_next == FULL);
      end
   end

   assign parallel_out = hold_reg;
   assign out_valid    = valid_reg;
   assign overrun      = overrun_reg;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_sipo_deser;

   logic       clk = 1'b0;
   logic       rst, shift_en, serial_in, frame_clr, out_ready, ovr_clr;
   logic [3:0] po_m, po_l;
   logic       ov_m, ov_l, ovr_m, ovr_l;
   logic [1:0] cnt_m, cnt_l;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .shift_en(shift_en), .serial_in(serial_in),
      .frame_clr(frame_clr), .parallel_out(po_m), .out_valid(ov_m),
      .out_ready(out_ready), .bit_cnt(cnt_m), .overrun(ovr_m), .ovr_clr(ovr_clr)
   );

   sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .shift_en(shift_en), .serial_in(serial_in),
      .frame_clr(frame_clr), .parallel_out(po_l), .out_valid(ov_l),
      .out_ready(out_ready), .bit_cnt(cnt_l), .overrun(ovr_l), .ovr_clr(ovr_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample 1 ns after the rising edge.
   task automatic step(input logic s, input logic b, input logic fc,
                       input logic rdy, input logic oc, input logic r);
      shift_en  = s;
      serial_in = b;
      frame_clr = fc;
      out_ready = rdy;
      ovr_clr   = oc;
      rst       = r;
      @(posedge clk);
      #1;
      $display("t=%0t en=%b si=%b fc=%b rdy=%b oc=%b rst=%b | po=%h/%h v=%b cnt=%0d ovr=%b",
               $time, s, b, fc, rdy, oc, r, po_m, po_l, ov_m, cnt_m, ovr_m);
   endtask

   task automatic shift_bit(input logic b);
      step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; shift_en = 1'b0; serial_in = 1'b0;
      frame_clr = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0;
      @(negedge clk);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      check("rst_valid", ov_m, 1'b0);
      check("rst_po", po_m, 4'h0);
      check("rst_cnt", cnt_m, 2'd0);
      check("rst_ovr", ovr_m, 1'b0);

      // Basic receive 1,1,0,1
      shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
      check("basic_cnt3", cnt_m, 2'd3);
      check("basic_notvalid", ov_m, 1'b0);
      shift_bit(1'b1);
      check("basic_valid", ov_m, 1'b1);
      check("basic_po", po_m, 4'hD);
      check("basic_cnt0", cnt_m, 2'd0);
      check("lsb_po", po_l, 4'hB);

      // Overrun: 0,1,1,0 while full and not accepted
      shift_bit(1'b0); shift_bit(1'b1);
      check("stable_po", po_m, 4'hD);
      check("stable_valid", ov_m, 1'b1);
      shift_bit(1'b1); shift_bit(1'b0);
      check("ovr_po", po_m, 4'hD);
      check("ovr_set", ovr_m, 1'b1);
      check("ovr_set_lsb", ovr_l, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("ovr_clr", ovr_m, 1'b0);
      check("ovr_clr_valid", ov_m, 1'b1);

      // Set wins over a simultaneous clear
      shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("ovr_setwins", ovr_m, 1'b1);
      check("ovr_setwins_po", po_m, 4'hD);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("ovr_clr2", ovr_m, 1'b0);

      // Accept and completion on the same edge: 1,0,1,0
      shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("simul_valid", ov_m, 1'b1);
      check("simul_po", po_m, 4'hA);
      check("simul_ovr", ovr_m, 1'b0);
      check("simul_po_lsb", po_l, 4'h5);

      // Plain accept, then ready while empty
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("accept_empty", ov_m, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("ready_empty", ov_m, 1'b0);

      // frame_clr mid-word beats shift_en
      shift_bit(1'b1); shift_bit(1'b1);
      check("fc_pre_cnt", cnt_m, 2'd2);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("fc_cnt", cnt_m, 2'd0);
      shift_bit(1'b0); shift_bit(1'b0);
      check("fc_nocomplete", ov_m, 1'b0);
      shift_bit(1'b1);
      check("fc_cnt3", cnt_m, 2'd3);
      check("fc_nocomplete2", ov_m, 1'b0);
      shift_bit(1'b1);
      check("fc_valid", ov_m, 1'b1);
      check("fc_po", po_m, 4'h3);
      check("fc_po_lsb", po_l, 4'hC);

      // Reset mid-operation while full, overrun set, bit_cnt=2
      shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
      check("pre_rst_ovr", ovr_m, 1'b1);
      shift_bit(1'b1); shift_bit(1'b1);
      check("pre_rst_cnt", cnt_m, 2'd2);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("mrst_valid", ov_m, 1'b0);
      check("mrst_po", po_m, 4'h0);
      check("mrst_cnt", cnt_m, 2'd0);
      check("mrst_ovr", ovr_m, 1'b0);
      shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
      check("post_rst_valid", ov_m, 1'b1);
      check("post_rst_po", po_m, 4'hD);
      check("post_rst_po_lsb", po_l, 4'hB);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
